// File: rtl/audio_sample_feeder_pkg.sv
// Shared types for the audio feeder: stereo frame layout and per-channel
// attenuation used on the way out to the PWM stage.
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } frame_t;

  localparam int FRAME_W   = 16;
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = FRAME_W / NUM_LANES;

  // Shift first, then mute; arithmetic shift keeps negative samples negative.
  function automatic sample_t atten(input sample_t s, input logic [2:0] sh,
                                    input logic mute);
    sample_t y;
    y = s >>> sh;
    if (mute) y = '0;
    return y;
  endfunction

endpackage

// File: rtl/audio_sample_feeder_fifo.sv
// First-word fall-through frame FIFO; push is ignored when full, pop when empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        push,
  input  logic        pop,
  input  frame_t      din,
  output frame_t      dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  frame_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly AW bits, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/audio_sample_feeder.sv
// Sample-rate tick generator, frame buffer and output stage feeding the
// stereo PWM block; underruns play silence and are counted.
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter  int CLK_HZ     = 100_000_000,
  parameter  int SAMPLE_HZ  = 48_000,
  parameter  int FIFO_DEPTH = 16,
  parameter  int UNDERRUN_W = 16,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  s_valid_in,
  output logic                  s_ready_out,
  input  sample_t               s_left_in,
  input  sample_t               s_right_in,
  input  logic                  mute_in,
  input  logic [2:0]            vol_shift_in,
  output logic                  tick_out,
  output sample_t               sample_l_out,
  output sample_t               sample_r_out,
  output logic [LVL_W-1:0]      level_out,
  output logic                  underrun_out,
  output logic [UNDERRUN_W-1:0] underrun_count_out
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam logic [ACC_W-1:0] STEP    = ACC_W'(SAMPLE_HZ);
  localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0]                   r_acc;
  logic [ACC_W-1:0]                   w_nxt;
  logic                               w_tick;
  logic                               r_tick;
  logic                               r_underrun;
  logic [UNDERRUN_W-1:0]              r_underrun_cnt;
  logic [NUM_LANES-1:0][VEC_W-1:0]    r_sample;
  logic [NUM_LANES-1:0][VEC_W-1:0]    w_raw;
  logic [NUM_LANES-1:0][VEC_W-1:0]    w_proc;
  frame_t                             w_din;
  frame_t                             w_head;
  logic                               w_full;
  logic                               w_empty;
  logic                               w_push;
  logic [LVL_W-1:0]                   w_count;

  // Fractional phase accumulator: spacing alternates floor/ceil of CLK_HZ/SAMPLE_HZ.
  assign w_nxt  = r_acc + STEP;
  assign w_tick = (w_nxt >= MODULUS);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_acc <= '0;
    else if (w_tick) r_acc <= w_nxt - MODULUS;
    else r_acc <= w_nxt;
  end

  assign s_ready_out = !w_full;
  assign w_push      = s_valid_in && s_ready_out;
  assign w_din       = '{l: s_left_in, r: s_right_in};

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (w_push),
    .pop      (w_tick),
    .din      (w_din),
    .dout     (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count)
  );

  // Lane 1 carries left, lane 0 right, matching the packed frame layout.
  assign w_raw = w_head;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_proc[g] = atten(sample_t'(w_raw[g]), vol_shift_in, mute_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tick         <= 1'b0;
      r_underrun     <= 1'b0;
      r_sample       <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_tick     <= w_tick;
      r_underrun <= w_tick && w_empty;
      if (w_tick) begin
        r_sample <= w_empty ? '0 : w_proc;
        if (w_empty && (r_underrun_cnt != {UNDERRUN_W{1'b1}}))
          r_underrun_cnt <= r_underrun_cnt + 1'b1;
      end
    end
  end

  assign tick_out           = r_tick;
  assign underrun_out       = r_underrun;
  assign underrun_count_out = r_underrun_cnt;
  assign sample_l_out       = sample_t'(r_sample[1]);
  assign sample_r_out       = sample_t'(r_sample[0]);
  assign level_out          = w_count;

endmodule

// File: doc/audio_sample_feeder.md
Name: audio_sample_feeder

Overview:
Upstream stage of the stereo PWM output. It generates the audio sample-rate tick from the system clock and buffers stereo frames from a producer (tone generator, sample player or DMA) in a small FIFO. It pops exactly one frame per tick, applies mute and volume attenuation, and drives held signed 8-bit left/right samples plus the tick straight into the PWM stage. Underruns are detected, replaced with silence, and counted.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
SAMPLE_HZ, 48_000, output sample rate in Hz; must be < CLK_HZ/2
FIFO_DEPTH, 16, stereo frames buffered; power of two, >= 2
UNDERRUN_W, 16, width of the saturating underrun counter

Ports:
clk_in  input  1  system clock; the only clock
rst_n_in  input  1  asynchronous, active-low reset
s_valid_in  input  1  producer has a frame on s_left_in/s_right_in
s_ready_out  output  1  feeder can accept a frame this cycle
s_left_in  input  8  signed left sample
s_right_in  input  8  signed right sample
mute_in  input  1  force output samples to 0; FIFO keeps draining
vol_shift_in  input  3  arithmetic right-shift attenuation, 0..7
tick_out  output  1  one-cycle pulse at SAMPLE_HZ
sample_l_out  output  8  signed held left sample
sample_r_out  output  8  signed held right sample
level_out  output  $clog2(FIFO_DEPTH)+1  frames currently in the FIFO
underrun_out  output  1  one-cycle pulse, coincident with tick_out, when a tick found the FIFO empty
underrun_count_out  output  UNDERRUN_W  saturating underrun total

Behaviour:
- Reset (rst_n_in low, async): phase accumulator = 0; FIFO empty; tick_out, underrun_out = 0; sample_l_out, sample_r_out = 0; underrun_count_out = 0; level_out = 0. s_ready_out = 1 once out of reset.
- Tick generation uses a phase accumulator (width >= $clog2(CLK_HZ)+1). Each cycle, nxt = acc + SAMPLE_HZ. If nxt >= CLK_HZ: acc <= nxt - CLK_HZ and tick_int = 1. Otherwise acc <= nxt.
- Tick timing is exact on average, with spacing floor or ceil of CLK_HZ/SAMPLE_HZ (2083/2084 cycles at the defaults). The first tick occurs about 2084 cycles after reset release.
- tick_out is registered: it is high for the one cycle after tick_int. The sample outputs update on the same edge that raises tick_out.
- Push: a frame is written when s_valid_in && s_ready_out. s_ready_out = (level < FIFO_DEPTH), combinational from the count register. The producer may hold s_valid_in high; data must be stable until accepted.
- Pop on tick_int, FIFO non-empty: pop the head frame and register the processed samples to the outputs.
- Pop on tick_int, FIFO empty: outputs load 0; underrun_out pulses with tick_out; the counter increments and saturates at 2^UNDERRUN_W-1 (no wrap).
- Outputs hold their value between ticks.
- Processing, per channel, applied in this order:
  - y = sample >>> vol_shift_in (sign-preserving: -1 stays -1, -128>>>7 = -1).
  - If mute_in, y = 0.
  - mute_in and vol_shift_in are sampled in the tick_int cycle only.
- Same-cycle push and tick with the FIFO non-empty and not full: both occur; level is unchanged.
- Push when full: not accepted (s_ready_out low). A pop in that cycle raises s_ready_out in the following cycle.
- Push and tick on an empty FIFO: no bypass. The tick counts as an underrun; the pushed frame is stored and popped at the next tick.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. level_out is the registered count, 0..FIFO_DEPTH.
- Reset mid-stream: all outputs clear immediately; buffered frames are discarded; after release, the tick phase restarts from 0.

Decomposition:
- Package audio_pkg:
  - typedef sample_t = logic signed [7:0]
  - typedef struct packed { sample_t l; sample_t r; } frame_t
  - localparam FRAME_W = 16
- Sub-module sample_fifo: synchronous FIFO of frame_t, parameter DEPTH. Ports: push, pop, din, dout (first-word fall-through), full, empty, count. Async active-low reset.
- Tick accumulator, processing and underrun logic stay in the top.

Test Plan:
- Tick rate: run 1,000,000 cycles after reset with defaults -> exactly 480 tick_out pulses, each one cycle wide, spacing only 2083 or 2084.
- Ordering and underrun: push (10,-20), (127,-128), (0,5), then idle -> the next three ticks output those frames in order. The fourth tick outputs (0,0) with underrun_out=1 and underrun_count_out=1.
- Full FIFO: hold s_valid_in with FIFO_DEPTH=16 before any tick -> 16 frames accepted, s_ready_out=0, level_out=16, 17th frame held off. After the next tick, level_out=15, s_ready_out=1 and the 17th frame is accepted.
- Attenuation: vol_shift_in=2 with frames (-128,127) and (-1,4) -> outputs (-32,31) then (-1,1). mute_in=1 -> (0,0) while level_out still decrements per tick.
- Saturation: force UNDERRUN_W=4, leave the FIFO empty for 20 ticks -> underrun_count_out stops at 15, underrun_out still pulses every tick.
- Async reset mid-stream: with 5 frames buffered and nonzero outputs, drop rst_n_in between clock edges -> outputs and level_out are 0 before the next edge. After release, the first tick outputs (0,0) as an underrun, and no stale frame is output.
